// File: rtl/instruction_decode_stage_pkg.sv
// Shared MIPS decode constants: control-bus widths, control bit positions and
// the immediate-extension opcodes used by the ID stage.
package instruction_decode_stage_pkg;

  localparam int DEF_NB_CTRL_WB  = 2;
  localparam int DEF_NB_CTRL_MEM = 3;
  localparam int DEF_NB_CTRL_EX  = 7;

  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;
  localparam int MEM_BRANCH   = 2;
  localparam int MEM_MEMREAD  = 1;
  localparam int MEM_MEMWRITE = 0;
  localparam int EX_REGDST    = 6;
  localparam int EX_ALUSRC    = 5;
  localparam int EX_JUMP      = 4;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_UPPER} ext_kind_e;

  // Logical immediates are unsigned, lui places the immediate in the top half.
  function automatic ext_kind_e ext_kind(input logic [5:0] op);
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: return EXT_ZERO;
      OP_LUI:                   return EXT_UPPER;
      default:                  return EXT_SIGN;
    endcase
  endfunction

endpackage

// File: rtl/instruction_decode_stage_if.sv
// IF/ID-to-ID/EX bus of the decode stage; master drives the IF/ID side and
// write-back, slave is the decode stage itself.
interface instruction_decode_stage_if
  import instruction_decode_stage_pkg::*;
#(
  parameter int LEN                  = 32,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int NB_CTRL_WB           = DEF_NB_CTRL_WB,
  parameter int NB_CTRL_MEM          = DEF_NB_CTRL_MEM,
  parameter int NB_CTRL_EX           = DEF_NB_CTRL_EX,
  parameter int NB_STALL_CNT         = 16
);
  logic                            i_valid;
  logic [LEN-1:0]                  i_instruccion;
  logic [LEN-1:0]                  i_adder_pc;
  logic [NB_CTRL_WB-1:0]           i_ctrl_wb;
  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem;
  logic [NB_CTRL_EX-1:0]           i_ctrl_ex;
  logic                            i_RegWrite;
  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg;
  logic [LEN-1:0]                  i_write_data;
  logic                            i_flush;
  logic                            o_stall;
  logic                            o_valid;
  logic [LEN-1:0]                  o_adder_pc;
  logic [LEN-1:0]                  o_dato1;
  logic [LEN-1:0]                  o_dato2;
  logic [LEN-1:0]                  o_sign_extend;
  logic [NB_ADDRESS_REGISTROS-1:0] o_rs;
  logic [NB_ADDRESS_REGISTROS-1:0] o_rt;
  logic [NB_ADDRESS_REGISTROS-1:0] o_rd;
  logic [NB_ADDRESS_REGISTROS-1:0] o_shamt;
  logic [NB_CTRL_WB-1:0]           o_ctrl_wb;
  logic [NB_CTRL_MEM-1:0]          o_ctrl_mem;
  logic [NB_CTRL_EX-1:0]           o_ctrl_ex;
  logic [NB_STALL_CNT-1:0]         o_stall_count;

  modport master (
    output i_valid, i_instruccion, i_adder_pc, i_ctrl_wb, i_ctrl_mem, i_ctrl_ex,
           i_RegWrite, i_write_reg, i_write_data, i_flush,
    input  o_stall, o_valid, o_adder_pc, o_dato1, o_dato2, o_sign_extend,
           o_rs, o_rt, o_rd, o_shamt, o_ctrl_wb, o_ctrl_mem, o_ctrl_ex, o_stall_count
  );

  modport slave (
    input  i_valid, i_instruccion, i_adder_pc, i_ctrl_wb, i_ctrl_mem, i_ctrl_ex,
           i_RegWrite, i_write_reg, i_write_data, i_flush,
    output o_stall, o_valid, o_adder_pc, o_dato1, o_dato2, o_sign_extend,
           o_rs, o_rt, o_rd, o_shamt, o_ctrl_wb, o_ctrl_mem, o_ctrl_ex, o_stall_count
  );
endinterface

// File: rtl/instruction_decode_stage_reg_file_bypass.sv
// MIPS register file with write-through bypass: a same-cycle write-back to a
// register being read is forwarded to the read port.
module reg_file_bypass #(
  parameter int LEN                  = 32,
  parameter int CANTIDAD_REGISTROS   = 32,
  parameter int NB_ADDRESS_REGISTROS = $clog2(CANTIDAD_REGISTROS)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_we,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_waddr,
  input  logic signed [LEN-1:0]           i_wdata,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_raddr1,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_raddr2,
  output logic signed [LEN-1:0]           o_rdata1,
  output logic signed [LEN-1:0]           o_rdata2
);
  logic signed [LEN-1:0] regs [CANTIDAD_REGISTROS];
  logic                  wr_en;

  assign wr_en = i_we && (i_waddr != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < CANTIDAD_REGISTROS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  // r0 is hard-wired to zero even if the array entry were ever disturbed.
  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if (i_raddr1 != '0) o_rdata1 = (wr_en && i_waddr == i_raddr1) ? i_wdata : regs[i_raddr1];
    if (i_raddr2 != '0) o_rdata2 = (wr_en && i_waddr == i_raddr2) ? i_wdata : regs[i_raddr2];
  end
endmodule

// File: rtl/instruction_decode_stage.sv
// MIPS ID stage: field decode, immediate extension, load-use hazard detection
// with stall counting, and the ID/EX pipeline register.
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
#(
  parameter int LEN                  = 32,
  parameter int CANTIDAD_REGISTROS   = 32,
  parameter int NB_ADDRESS_REGISTROS = $clog2(CANTIDAD_REGISTROS),
  parameter int NB_CTRL_WB           = DEF_NB_CTRL_WB,
  parameter int NB_CTRL_MEM          = DEF_NB_CTRL_MEM,
  parameter int NB_CTRL_EX           = DEF_NB_CTRL_EX,
  parameter int NB_STALL_CNT         = 16
) (
  input logic i_clk,
  input logic i_rst,
  instruction_decode_stage_if.slave bus
);
  logic [5:0]                      opcode;
  logic [NB_ADDRESS_REGISTROS-1:0] rs, rt, rd, shamt;
  logic [15:0]                     imm;
  logic signed [LEN-1:0]           rdata1, rdata2, ext_imm;
  logic                            hazard, stall, bubble;

  logic                            vld_p1;
  logic [LEN-1:0]                  pc_p1;
  logic signed [LEN-1:0]           dato1_p1, dato2_p1, sext_p1;
  logic [NB_ADDRESS_REGISTROS-1:0] rs_p1, rt_p1, rd_p1, shamt_p1;
  logic [NB_CTRL_WB-1:0]           wb_p1;
  logic [NB_CTRL_MEM-1:0]          mem_p1;
  logic [NB_CTRL_EX-1:0]           ex_p1;
  logic [NB_STALL_CNT-1:0]         stall_cnt;

  function automatic logic signed [LEN-1:0] extend_imm(input ext_kind_e kind, input logic [15:0] val);
    logic [LEN-1:0] r;
    r = '0;
    case (kind)
      EXT_ZERO:  r[15:0]  = val;
      EXT_UPPER: r[31:16] = val;
      default:   r = {{(LEN-16){val[15]}}, val};
    endcase
    return signed'(r);
  endfunction

  function automatic logic [NB_STALL_CNT-1:0] sat_inc(input logic [NB_STALL_CNT-1:0] v);
    return (&v) ? v : v + NB_STALL_CNT'(1);
  endfunction

  assign opcode  = bus.i_instruccion[31:26];
  assign rs      = NB_ADDRESS_REGISTROS'(bus.i_instruccion[25:21]);
  assign rt      = NB_ADDRESS_REGISTROS'(bus.i_instruccion[20:16]);
  assign rd      = NB_ADDRESS_REGISTROS'(bus.i_instruccion[15:11]);
  assign shamt   = NB_ADDRESS_REGISTROS'(bus.i_instruccion[10:6]);
  assign imm     = bus.i_instruccion[15:0];
  assign ext_imm = extend_imm(ext_kind(opcode), imm);

  reg_file_bypass #(
    .LEN                 (LEN),
    .CANTIDAD_REGISTROS  (CANTIDAD_REGISTROS),
    .NB_ADDRESS_REGISTROS(NB_ADDRESS_REGISTROS)
  ) u_reg_file (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (bus.i_RegWrite),
    .i_waddr (bus.i_write_reg),
    .i_wdata (signed'(bus.i_write_data)),
    .i_raddr1(rs),
    .i_raddr2(rt),
    .o_rdata1(rdata1),
    .o_rdata2(rdata2)
  );

  // A load in EX whose target is read by the instruction in ID must wait a cycle.
  assign hazard = vld_p1 && mem_p1[MEM_MEMREAD] && (rt_p1 != '0) && bus.i_valid &&
                  ((rt_p1 == rs) || (rt_p1 == rt));
  assign stall  = hazard && !bus.i_flush;
  assign bubble = bus.i_flush || stall || !bus.i_valid;

  // ---- ID -> EX boundary ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1    <= 1'b0;
      stall_cnt <= '0;
      pc_p1     <= '0;
      dato1_p1  <= '0;
      dato2_p1  <= '0;
      sext_p1   <= '0;
      rs_p1     <= '0;
      rt_p1     <= '0;
      rd_p1     <= '0;
      shamt_p1  <= '0;
      wb_p1     <= '0;
      mem_p1    <= '0;
      ex_p1     <= '0;
    end else begin
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (bubble) begin
        vld_p1   <= 1'b0;
        pc_p1    <= '0;
        dato1_p1 <= '0;
        dato2_p1 <= '0;
        sext_p1  <= '0;
        rs_p1    <= '0;
        rt_p1    <= '0;
        rd_p1    <= '0;
        shamt_p1 <= '0;
        wb_p1    <= '0;
        mem_p1   <= '0;
        ex_p1    <= '0;
      end else begin
        vld_p1   <= 1'b1;
        pc_p1    <= bus.i_adder_pc;
        dato1_p1 <= rdata1;
        dato2_p1 <= rdata2;
        sext_p1  <= ext_imm;
        rs_p1    <= rs;
        rt_p1    <= rt;
        rd_p1    <= rd;
        shamt_p1 <= shamt;
        wb_p1    <= bus.i_ctrl_wb;
        mem_p1   <= bus.i_ctrl_mem;
        ex_p1    <= bus.i_ctrl_ex;
      end
    end
  end

  assign bus.o_stall       = stall;
  assign bus.o_valid       = vld_p1;
  assign bus.o_adder_pc    = pc_p1;
  assign bus.o_dato1       = dato1_p1;
  assign bus.o_dato2       = dato2_p1;
  assign bus.o_sign_extend = sext_p1;
  assign bus.o_rs          = rs_p1;
  assign bus.o_rt          = rt_p1;
  assign bus.o_rd          = rd_p1;
  assign bus.o_shamt       = shamt_p1;
  assign bus.o_ctrl_wb     = wb_p1;
  assign bus.o_ctrl_mem    = mem_p1;
  assign bus.o_ctrl_ex     = ex_p1;
  assign bus.o_stall_count = stall_cnt;
endmodule

// File: tb/tb_instruction_decode_stage.sv
// Scoreboard bench for instruction_decode_stage: directed IF/ID vectors with
// hand-computed ID/EX results, plus a 2-bit stall-counter instance.
module tb_instruction_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid, flush, we;
  logic [31:0] ins, pc, wdata;
  logic [4:0]  wreg;
  logic [1:0]  cwb;
  logic [2:0]  cmem;
  logic [6:0]  cex;

  instruction_decode_stage_if #(.NB_STALL_CNT(16)) bus ();
  instruction_decode_stage_if #(.NB_STALL_CNT(2))  bus_s ();

  assign bus.i_valid = valid;         assign bus_s.i_valid = valid;
  assign bus.i_instruccion = ins;     assign bus_s.i_instruccion = ins;
  assign bus.i_adder_pc = pc;         assign bus_s.i_adder_pc = pc;
  assign bus.i_ctrl_wb = cwb;         assign bus_s.i_ctrl_wb = cwb;
  assign bus.i_ctrl_mem = cmem;       assign bus_s.i_ctrl_mem = cmem;
  assign bus.i_ctrl_ex = cex;         assign bus_s.i_ctrl_ex = cex;
  assign bus.i_RegWrite = we;         assign bus_s.i_RegWrite = we;
  assign bus.i_write_reg = wreg;      assign bus_s.i_write_reg = wreg;
  assign bus.i_write_data = wdata;    assign bus_s.i_write_data = wdata;
  assign bus.i_flush = flush;         assign bus_s.i_flush = flush;

  instruction_decode_stage #(.NB_STALL_CNT(16)) u_dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  instruction_decode_stage #(.NB_STALL_CNT(2))  u_sat (.i_clk(clk), .i_rst(rst), .bus(bus_s));

  typedef struct packed {
    logic [31:0] pc, d1, d2, sx;
    logic [19:0] fields;
    logic [11:0] ctrl;
  } exp_t;

  exp_t        exq[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] pc_cnt = 32'h0000_0400;

  localparam logic [11:0] C_ADD = {2'b10, 3'b000, 7'b1000010};
  localparam logic [11:0] C_LW  = {2'b11, 3'b010, 7'b0100000};
  localparam logic [11:0] C_IMM = {2'b10, 3'b000, 7'b0100011};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs_f, rt_f, rd_f, sh_f);
    return {6'h00, rs_f, rt_f, rd_f, sh_f, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs_f, rt_f, input logic [15:0] im);
    return {op, rs_f, rt_f, im};
  endfunction

  task automatic step(input logic v, input logic [31:0] iw, input logic [11:0] c, input logic fl,
                      input logic we_i, input logic [4:0] wr, input logic [31:0] wd,
                      input logic stall_exp, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] sx);
    exp_t e;
    @(negedge clk);
    pc_cnt = pc_cnt + 32'd4;
    valid = v; ins = iw; {cwb, cmem, cex} = c; flush = fl;
    we = we_i; wreg = wr; wdata = wd; pc = pc_cnt;
    if (v && !fl && !stall_exp) begin
      e.pc = pc_cnt; e.d1 = d1; e.d2 = d2; e.sx = sx;
      e.fields = {iw[25:21], iw[20:16], iw[15:11], iw[10:6]};
      e.ctrl = c;
      exq.push_back(e);
    end
    #1 chk("stall", 64'(bus.o_stall), 64'(stall_exp));
  endtask

  task automatic idle(input logic we_i, input logic [4:0] wr, input logic [31:0] wd);
    step(1'b0, 32'h0, 12'h0, 1'b0, we_i, wr, wd, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, "_stall"}, 64'(bus.o_stall), 64'd0);
    chk({tag, "_count"}, 64'(bus.o_stall_count), 64'd0);
    chk({tag, "_ctrl"}, 64'({bus.o_ctrl_wb, bus.o_ctrl_mem, bus.o_ctrl_ex}), 64'd0);
    chk({tag, "_data"}, 64'(bus.o_dato1 | bus.o_dato2 | bus.o_sign_extend | bus.o_adder_pc), 64'd0);
  endtask

  // Monitor: pops one expectation per valid ID/EX slot, checks bubbles are zeroed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.o_valid) begin
          if (exq.size() == 0) begin
            chk("unexpected_issue", 64'(bus.o_adder_pc), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exq.pop_front();
            chk("pc", 64'(bus.o_adder_pc), 64'(e.pc));
            chk("dato1", 64'(bus.o_dato1), 64'(e.d1));
            chk("dato2", 64'(bus.o_dato2), 64'(e.d2));
            chk("sext", 64'(bus.o_sign_extend), 64'(e.sx));
            chk("fields", 64'({bus.o_rs, bus.o_rt, bus.o_rd, bus.o_shamt}), 64'(e.fields));
            chk("ctrl", 64'({bus.o_ctrl_wb, bus.o_ctrl_mem, bus.o_ctrl_ex}), 64'(e.ctrl));
          end
        end else begin
          chk("bubble_ctrl", 64'({bus.o_ctrl_wb, bus.o_ctrl_mem, bus.o_ctrl_ex}), 64'd0);
          chk("bubble_data", 64'(bus.o_dato1 | bus.o_dato2 | bus.o_sign_extend | bus.o_adder_pc) |
                             64'({bus.o_rs, bus.o_rt, bus.o_rd, bus.o_shamt}), 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    valid = 0; flush = 0; we = 0; ins = 0; pc = 0; wdata = 0; wreg = 0;
    cwb = 0; cmem = 0; cex = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid = 1'($urandom); ins = $urandom; pc = $urandom; flush = 1'($urandom);
      we = 1'($urandom); wreg = 5'($urandom); wdata = $urandom;
      {cwb, cmem, cex} = 12'($urandom);
      #1 reset_outputs_zero("reset");
    end
    valid = 0; flush = 0; we = 0;
    rst = 0;

    // Reads after reset, shamt field carried through
    step(1, rtype(5'd3, 5'd4, 5'd10, 5'd3), C_ADD, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_50E0);
    // Same-cycle write-back bypass, then r0 write ignored
    step(1, rtype(5'd5, 5'd0, 5'd11, 5'd0), C_ADD, 0, 1, 5'd5, 32'hDEAD_BEEF, 0,
         32'hDEAD_BEEF, 32'h0, 32'h0000_5820);
    step(1, rtype(5'd0, 5'd5, 5'd12, 5'd0), C_ADD, 0, 1, 5'd0, 32'h0000_1234, 0,
         32'h0, 32'hDEAD_BEEF, 32'h0000_6020);
    idle(1, 5'd1, 32'h1111_1111);
    idle(1, 5'd8, 32'h0000_0100);

    // Load-use: one stall, one bubble, then the add issues
    step(1, itype(6'h23, 5'd1, 5'd8, 16'h0004), C_LW, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h100, 32'h4);
    step(1, rtype(5'd8, 5'd1, 5'd9, 5'd0), C_ADD, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, rtype(5'd8, 5'd1, 5'd9, 5'd0), C_ADD, 0, 0, 0, 0, 0, 32'h100, 32'h1111_1111, 32'h0000_4820);
    chk("count_after_stall", 64'(bus.o_stall_count), 64'd1);
    chk("sat_count_after_stall", 64'(bus_s.o_stall_count), 64'd1);

    // Flush beats stall and does not count
    step(1, itype(6'h23, 5'd1, 5'd8, 16'h0004), C_LW, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h100, 32'h4);
    step(1, rtype(5'd8, 5'd1, 5'd9, 5'd0), C_ADD, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    chk("count_after_flush", 64'(bus.o_stall_count), 64'd1);

    // Immediate extension by opcode
    step(1, itype(6'h08, 5'd0, 5'd3, 16'h8001), C_IMM, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_8001);
    step(1, itype(6'h0D, 5'd0, 5'd3, 16'h8001), C_IMM, 0, 0, 0, 0, 0, 0, 0, 32'h0000_8001);
    step(1, itype(6'h0F, 5'd0, 5'd3, 16'h8001), C_IMM, 0, 0, 0, 0, 0, 0, 0, 32'h8001_0000);
    step(1, itype(6'h0C, 5'd0, 5'd3, 16'h8001), C_IMM, 0, 0, 0, 0, 0, 0, 0, 32'h0000_8001);
    step(1, itype(6'h0E, 5'd0, 5'd3, 16'h8001), C_IMM, 0, 0, 0, 0, 0, 0, 0, 32'h0000_8001);
    step(1, itype(6'h10, 5'd0, 5'd3, 16'h8001), C_IMM, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_8001);

    // No hazard: load to r0, independent use, invalid ID slot
    step(1, itype(6'h23, 5'd1, 5'd0, 16'h0004), C_LW, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h0, 32'h4);
    step(1, rtype(5'd0, 5'd1, 5'd9, 5'd0), C_ADD, 0, 0, 0, 0, 0, 32'h0, 32'h1111_1111, 32'h0000_4820);
    step(1, itype(6'h23, 5'd1, 5'd8, 16'h0004), C_LW, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h100, 32'h4);
    step(1, rtype(5'd1, 5'd2, 5'd9, 5'd0), C_ADD, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h0, 32'h0000_4820);
    step(1, itype(6'h23, 5'd1, 5'd8, 16'h0004), C_LW, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h100, 32'h4);
    step(0, rtype(5'd8, 5'd1, 5'd9, 5'd0), C_ADD, 0, 0, 0, 0, 0, 0, 0, 0);

    // Five more load-use stalls, matched on rs then rt alternately
    for (int i = 0; i < 5; i++) begin
      logic [31:0] dep, d1, d2;
      dep = (i % 2 == 0) ? rtype(5'd8, 5'd1, 5'd9, 5'd0) : rtype(5'd1, 5'd8, 5'd9, 5'd0);
      d1  = (i % 2 == 0) ? 32'h100 : 32'h1111_1111;
      d2  = (i % 2 == 0) ? 32'h1111_1111 : 32'h100;
      step(1, itype(6'h23, 5'd1, 5'd8, 16'h0004), C_LW, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h100, 32'h4);
      step(1, dep, C_ADD, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, dep, C_ADD, 0, 0, 0, 0, 0, d1, d2, 32'h0000_4820);
      chk("count_loop", 64'(bus.o_stall_count), 64'(2 + i));
      chk("sat_count_loop", 64'(bus_s.o_stall_count), 64'((2 + i > 3) ? 3 : 2 + i));
    end

    // Reset asserted mid-stall clears state asynchronously
    step(1, itype(6'h23, 5'd1, 5'd8, 16'h0004), C_LW, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h100, 32'h4);
    step(1, rtype(5'd8, 5'd1, 5'd9, 5'd0), C_ADD, 0, 0, 0, 0, 1, 0, 0, 0);
    #1 rst = 1;
    #1 reset_outputs_zero("midreset");
    chk("midreset_sat_count", 64'(bus_s.o_stall_count), 64'd0);
    @(negedge clk);
    valid = 0;
    rst = 0;
    step(1, rtype(5'd5, 5'd8, 5'd13, 5'd0), C_ADD, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_6820);
    idle(0, 0, 0);
    idle(0, 0, 0);
    chk("queue_drained", 64'(exq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 Parameters SHALL be: LEN=32, data/PC width; CANTIDAD_REGISTROS=32, register count; NB_ADDRESS_REGISTROS=$clog2(CANTIDAD_REGISTROS), register address width; NB_CTRL_WB=2; NB_CTRL_MEM=3; NB_CTRL_EX=7; NB_STALL_CNT=16, stall counter width.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named i_clk and i_rst.
REQ-003 Ports SHALL be (name  direction  width  meaning):
  i_clk  in  1  clock, rising edge;
  i_rst  in  1  async active-high reset;
  i_valid  in  1  IF/ID holds a real instruction;
  i_instruccion  in  LEN  instruction word;
  i_adder_pc  in  LEN  PC+4;
  i_ctrl_wb/i_ctrl_mem/i_ctrl_ex  in  NB_CTRL_*  control decode for i_instruccion ({RegWrite,MemtoReg}, {Branch,MemRead,MemWrite}, {RegDst,ALUSrc,Jump,alu_code[3:0]});
  i_RegWrite  in  1  WB write enable;
  i_write_reg  in  NB_ADDRESS_REGISTROS  WB destination;
  i_write_data  in  LEN  WB data;
  i_flush  in  1  discard the instruction in ID (taken branch/jump downstream);
  o_stall  out  1  hold PC and IF/ID this cycle;
  o_valid  out  1  ID/EX slot is real;
  o_adder_pc, o_dato1, o_dato2, o_sign_extend  out  LEN  registered ID/EX values;
  o_rs, o_rt, o_rd, o_shamt  out  NB_ADDRESS_REGISTROS  registered fields;
  o_ctrl_wb, o_ctrl_mem, o_ctrl_ex  out  NB_CTRL_*  registered control;
  o_stall_count  out  NB_STALL_CNT  load-use stall cycles since reset.

Function
REQ-004 Fields SHALL decode as rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], imm=[15:0], opcode=[31:26].
REQ-005 Immediate SHALL be: opcode 0x0C/0x0D/0x0E -> zero-extended; 0x0F -> {imm,16'b0}; all others -> sign-extended to LEN.
REQ-006 Register file SHALL write i_write_data to i_write_reg on rising i_clk when i_RegWrite=1 and i_write_reg!=0; register 0 SHALL always read 0.
REQ-007 Reads SHALL bypass: if i_RegWrite=1, i_write_reg!=0 and it equals rs (rt), the read value SHALL be i_write_data in the same cycle.
REQ-008 Load-use hazard SHALL be asserted when o_valid=1, o_ctrl_mem[1]=1, o_rt!=0, i_valid=1 and o_rt equals rs or rt of i_instruccion.
REQ-009 o_stall SHALL be combinational: hazard AND NOT i_flush.
REQ-010 On each rising edge, ID/EX SHALL load: bubble when i_flush=1 or o_stall=1 or i_valid=0; otherwise the decoded instruction with o_valid=1; latency from IF/ID to ID/EX outputs SHALL be one cycle.
REQ-011 A bubble SHALL set o_valid=0 and o_ctrl_wb, o_ctrl_mem, o_ctrl_ex to 0; other data outputs are don't-care but SHALL be written with 0.
REQ-012 i_flush SHALL take priority over stall; a flushed cycle SHALL NOT increment o_stall_count.
REQ-013 o_stall_count SHALL increment by 1 in every cycle o_stall=1 and saturate at all-ones.
REQ-014 A stalled instruction SHALL be re-presented by IF/ID next cycle and, the hazard gone, SHALL issue with o_valid=1; a load followed by a dependent instruction therefore costs exactly one bubble.

Reset
REQ-015 While i_rst=1, all ID/EX outputs, o_valid and o_stall_count SHALL be 0 and all registers in the register file SHALL be 0, independent of i_clk.
REQ-016 Reset asserted mid-stall SHALL clear o_valid, which SHALL deassert o_stall combinationally.
REQ-017 Deassertion SHALL take effect on the first rising edge after i_rst falls.

Structure
REQ-018 Control bit positions (RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc, Jump), opcodes 0x0C-0x0F and NB_CTRL_* defaults SHALL live in the shared MIPS package.
REQ-019 Register file with bypass SHALL be one sub-module, reg_file_bypass; hazard detection, extension and ID/EX register SHALL remain in this module.

Verification
REQ-020 Reset: i_rst=1 with random inputs -> all outputs 0, o_stall=0; register reads return 0 after release.
REQ-021 Bypass: WB writes r5=0xDEADBEEF while ID reads rs=5 in the same cycle -> o_dato1=0xDEADBEEF next edge; write to r0=0x1234 -> r0 reads 0.
REQ-022 Load-use: lw r8 issued, next add r9,r8,r1 -> o_stall=1 for one cycle, one bubble (o_valid=0, ctrl=0), add issues on the following edge, o_stall_count=1.
REQ-023 Flush priority: hazard condition plus i_flush=1 -> o_stall=0, bubble loaded, o_stall_count unchanged.
REQ-024 Immediates: imm=0x8001 on addi -> 0xFFFF8001; on ori -> 0x00008001; on lui -> 0x80010000.
REQ-025 Saturation: NB_STALL_CNT=2, five consecutive load-use stalls -> o_stall_count stays 3.
